// File: rtl/ahb_vga_dls.sv
// AHB-Lite write-only VGA frame buffer (80x60 cells of 8x8 px, 640x480) run as two lockstep cores with a sticky divergence flag.
// Latency: bus write lands one cycle after its address phase; HSYNC/VSYNC/RGB lag the scan counters by 2 HCLK.
// Backpressure: none, HREADYOUT is tied high and every transfer completes in zero wait states.

module ahb_vga_dls_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_sel,
    input  logic        bus_rdy,
    input  logic        bus_nseq,
    input  logic        bus_write,
    input  logic [12:0] bus_idx,
    input  logic [7:0]  bus_wdat,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  rgb
);
    localparam logic [12:0] CELLS = 13'd4800;

    logic        wr_pend_q, wr_pend_d;
    logic [12:0] wr_idx_q, wr_idx_d;
    logic        pix_en_q, pix_en_d;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        vis_s1_q, vis_s1_d;
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [12:0] rd_idx;
    logic [7:0]  rd_dat_q;
    logic [7:0]  mem [0:4799];

    // Next-state for bus capture, scan counters and the two-stage output pipeline
    always_comb begin
        wr_pend_d = bus_sel & bus_rdy & bus_nseq & bus_write;
        wr_idx_d  = bus_idx;
        pix_en_d  = ~pix_en_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        if (pix_en_q) begin
            if (hcnt_q == 10'd799) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == 10'd524) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
        rd_idx   = 13'(vcnt_q[9:3]) * 13'd80 + 13'(hcnt_q[9:3]);
        vis_s1_d = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
        hs_s1_d  = !((hcnt_q >= 10'd656) && (hcnt_q <= 10'd751));
        vs_s1_d  = !((vcnt_q >= 10'd490) && (vcnt_q <= 10'd491));
        rgb_d    = vis_s1_q ? rd_dat_q : 8'h00;
        hsync_d  = hs_s1_q;
        vsync_d  = vs_s1_q;
    end

    // Control and pipeline registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_pend_q <= 1'b0;
            wr_idx_q  <= 13'd0;
            pix_en_q  <= 1'b0;
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            vis_s1_q  <= 1'b0;
            hs_s1_q   <= 1'b1;
            vs_s1_q   <= 1'b1;
            rgb_q     <= 8'h00;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_idx_q  <= wr_idx_d;
            pix_en_q  <= pix_en_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            vis_s1_q  <= vis_s1_d;
            hs_s1_q   <= hs_s1_d;
            vs_s1_q   <= vs_s1_d;
            rgb_q     <= rgb_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    // Frame buffer write port; contents survive reset, out-of-range cells are dropped
    always_ff @(posedge clk) begin
        if (wr_pend_q && (wr_idx_q < CELLS)) begin
            mem[wr_idx_q] <= bus_wdat;
        end
    end

    // Synchronous read port; a same-cycle write to the same cell returns the old byte
    always_ff @(posedge clk) begin
        if (rd_idx < CELLS) begin
            rd_dat_q <= mem[rd_idx];
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;
endmodule

module ahb_vga_dls (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HSEL,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic [7:0]  RGB,
    output logic        DLS_ERROR
);
    logic        a_hs, a_vs, b_hs, b_vs;
    logic [7:0]  a_rgb, b_rgb;
    logic        dls_err_q, dls_err_d;
    logic        unused_bus_bits;

    assign unused_bus_bits = ^{HADDR[31:15], HADDR[1:0], HWDATA[31:8], HTRANS[0]};

    ahb_vga_dls_core u_core_a (
        .clk(HCLK), .rst_n(HRESETn), .bus_sel(HSEL), .bus_rdy(HREADY),
        .bus_nseq(HTRANS[1]), .bus_write(HWRITE), .bus_idx(HADDR[14:2]),
        .bus_wdat(HWDATA[7:0]), .hsync(a_hs), .vsync(a_vs), .rgb(a_rgb)
    );

    ahb_vga_dls_core u_core_b (
        .clk(HCLK), .rst_n(HRESETn), .bus_sel(HSEL), .bus_rdy(HREADY),
        .bus_nseq(HTRANS[1]), .bus_write(HWRITE), .bus_idx(HADDR[14:2]),
        .bus_wdat(HWDATA[7:0]), .hsync(b_hs), .vsync(b_vs), .rgb(b_rgb)
    );

    // Any divergence between the cores latches the error until reset
    always_comb begin
        dls_err_d = dls_err_q | ({a_hs, a_vs, a_rgb} != {b_hs, b_vs, b_rgb});
    end

    // Sticky lockstep error flag
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dls_err_q <= 1'b0;
        end else begin
            dls_err_q <= dls_err_d;
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRDATA    = 32'h0;
    assign HSYNC     = a_hs;
    assign VSYNC     = a_vs;
    assign RGB       = a_rgb;
    assign DLS_ERROR = dls_err_q;
endmodule

// File: tb/tb_ahb_vga_dls.sv
// Directed bench: bus write vectors with hand-computed pixel expectations, scan windows, sync timing and lockstep fault.
// Scan windows start from a chosen line by holding the row counters of both cores during a reset.
// Outputs are sampled 1 time unit after the rising edge.

module tb_ahb_vga_dls;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HSYNC;
    logic        VSYNC;
    logic [7:0]  RGB;
    logic        DLS_ERROR;

    always #5 HCLK = ~HCLK;

    ahb_vga_dls dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .RGB(RGB), .DLS_ERROR(DLS_ERROR)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  dat;
        logic        sel;
        logic        rdy;
        logic [1:0]  trans;
        logic        wr;
        int          line;
        int          pix;
        logic [7:0]  exp_rgb;
    } vec_t;

    localparam int NV = 13;
    vec_t        vecs [NV];
    logic [7:0]  shadow [0:4799];
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  fv;
    logic [7:0]  fault_val;
    int          vs_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [7:0] d, input logic s,
                                input logic r, input logic [1:0] t, input logic w,
                                input int l, input int p, input logic [7:0] e);
        vec_t v;
        v.addr = a; v.dat = d; v.sel = s; v.rdy = r; v.trans = t; v.wr = w;
        v.line = l; v.pix = p; v.exp_rgb = e;
        return v;
    endfunction

    // Expected {rgb, hsync, vsync} for the sample taken after the k-th edge since reset release
    function automatic logic [9:0] model(input int v0, input int k);
        int p, h, l;
        logic [7:0] c;
        if (k == 0) return {8'h00, 1'b1, 1'b1};
        p = (k - 1) / 2;
        h = p % 800;
        l = (v0 + p / 800) % 525;
        c = (h < 640 && l < 480) ? shadow[(l / 8) * 80 + h / 8] : 8'h00;
        return {c, !(h >= 656 && h < 752), !(l >= 490 && l < 492)};
    endfunction

    task automatic restart(input int v0);
        fv = 10'(v0);
        @(negedge HCLK);
        HRESETn = 1'b0;
        force dut.u_core_a.vcnt_q = fv;
        force dut.u_core_b.vcnt_q = fv;
        @(negedge HCLK);
        check("rst_hsync", 32'(HSYNC), 32'd1);
        check("rst_vsync", 32'(VSYNC), 32'd1);
        check("rst_rgb", 32'(RGB), 32'd0);
        check("rst_dls", 32'(DLS_ERROR), 32'd0);
        HRESETn = 1'b1;
    endtask

    task automatic scan(input int v0, input int nlines, output int vlow);
        int nsamp, line_err, bad_k, hs_fall, d;
        logic [9:0] e, bad_act;
        logic prev_hs;
        nsamp = nlines * 1600 + 1;
        line_err = 0; bad_k = 0; bad_act = '0; hs_fall = -1; prev_hs = 1'b1; vlow = 0;
        restart(v0);
        for (int k = 0; k < nsamp; k++) begin
            @(posedge HCLK);
            #1;
            if (k == 0) begin
                release dut.u_core_a.vcnt_q;
                release dut.u_core_b.vcnt_q;
            end
            e = model(v0, k);
            if ({RGB, HSYNC, VSYNC} !== e || DLS_ERROR !== 1'b0) begin
                if (line_err == 0) begin
                    bad_k = k;
                    bad_act = {RGB, HSYNC, VSYNC};
                end
                line_err++;
            end
            for (int i = 0; i < NV; i++) begin
                d = (vecs[i].line - v0 + 525) % 525;
                if (d < nlines && k == 2 * (d * 800 + vecs[i].pix) + 1)
                    check($sformatf("pix_v%0d", i), 32'(RGB), 32'(vecs[i].exp_rgb));
            end
            if (prev_hs && !HSYNC) begin
                if (hs_fall >= 0) check("hsync_period", 32'(k - hs_fall), 32'd1600);
                hs_fall = k;
            end
            if (!prev_hs && HSYNC) check("hsync_low", 32'(k - hs_fall), 32'd192);
            prev_hs = HSYNC;
            if (!VSYNC) vlow++;
            if (k > 0 && k % 1600 == 0) begin
                checks++;
                if (line_err != 0) begin
                    errors++;
                    $display("FAIL scan_v%0d_l%0d: %0d bad samples, first at k=%0d got {rgb,hs,vs}=%0h expected %0h",
                             v0, (k - 1) / 1600, line_err, bad_k, bad_act, model(v0, bad_k));
                end
                line_err = 0;
            end
        end
    endtask

    initial begin
        vecs[0]  = mk(32'h0000_0000, 8'hE0, 1, 1, 2'b10, 1,   0,   0, 8'hE0);
        vecs[1]  = mk(32'h0000_4AFC, 8'h1C, 1, 1, 2'b10, 1, 479, 639, 8'h1C);
        vecs[2]  = mk(32'h0000_0144, 8'h3C, 1, 1, 2'b11, 1,   8,   8, 8'h3C);
        vecs[3]  = mk(32'h0000_4B00, 8'hFF, 1, 1, 2'b10, 1, 480,   0, 8'h00);
        vecs[4]  = mk(32'h0000_0008, 8'hAA, 0, 1, 2'b10, 1,   0,  16, 8'h00);
        vecs[5]  = mk(32'h0000_000C, 8'hBB, 1, 1, 2'b00, 1,   0,  24, 8'h00);
        vecs[6]  = mk(32'h0000_0010, 8'hCC, 1, 1, 2'b10, 0,   7,  32, 8'h00);
        vecs[7]  = mk(32'h0000_0014, 8'h77, 1, 1, 2'b01, 1,   0,  40, 8'h00);
        vecs[8]  = mk(32'h0000_4AF8, 8'h93, 1, 1, 2'b11, 1, 472, 631, 8'h93);
        vecs[9]  = mk(32'h8000_0018, 8'h5A, 1, 1, 2'b10, 1,   3,  48, 8'h5A);
        vecs[10] = mk(32'h0000_013C, 8'h4D, 1, 1, 2'b10, 1,   7, 639, 8'h4D);
        vecs[11] = mk(32'h0000_0000, 8'h00, 0, 1, 2'b10, 1,   0, 640, 8'h00);
        vecs[12] = mk(32'h0000_001C, 8'h66, 1, 0, 2'b10, 1,   0,  56, 8'h00);

        HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00; HWDATA = '0;
        HWRITE = 1'b0; HSEL = 1'b0; HREADY = 1'b1;
        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        check("reset_hsync", 32'(HSYNC), 32'd1);
        check("reset_vsync", 32'(VSYNC), 32'd1);
        check("reset_rgb", 32'(RGB), 32'd0);
        check("reset_dls", 32'(DLS_ERROR), 32'd0);
        check("reset_hreadyout", 32'(HREADYOUT), 32'd1);
        check("reset_hrdata", HRDATA, 32'd0);
        HRESETn = 1'b1;

        // Back-to-back clear of every cell
        for (int i = 0; i < 4800; i++) begin
            @(negedge HCLK);
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HREADY = 1'b1;
            HADDR = 32'(i) << 2; HWDATA = '0;
            shadow[i] = 8'h00;
        end
        // Vector transfers, pipelined: data of transfer i-1 rides with address of transfer i
        for (int i = 0; i < NV; i++) begin
            @(negedge HCLK);
            HSEL = vecs[i].sel; HREADY = vecs[i].rdy; HTRANS = vecs[i].trans;
            HWRITE = vecs[i].wr; HADDR = vecs[i].addr;
            HWDATA = (i == 0) ? 32'h0 : {24'h0, vecs[i-1].dat};
            if (vecs[i].sel && vecs[i].rdy && vecs[i].trans[1] && vecs[i].wr
                && vecs[i].addr[14:2] < 13'd4800)
                shadow[vecs[i].addr[14:2]] = vecs[i].dat;
        end
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
        HWDATA = {24'h0, vecs[NV-1].dat};
        @(negedge HCLK);
        HWDATA = '0;
        check("hrdata_idle", HRDATA, 32'd0);

        scan(0, 9, vs_low);
        check("vsync_low_top", 32'(vs_low), 32'd0);
        scan(471, 10, vs_low);
        scan(488, 6, vs_low);
        check("vsync_low_len", 32'(vs_low), 32'd3200);
        scan(523, 4, vs_low);

        // Lockstep fault: corrupt core B's colour register for one cycle
        @(negedge HCLK);
        check("dls_pre_fault", 32'(DLS_ERROR), 32'd0);
        fault_val = ~RGB;
        force dut.u_core_b.rgb_q = fault_val;
        @(posedge HCLK);
        #1;
        check("dls_set", 32'(DLS_ERROR), 32'd1);
        @(negedge HCLK);
        release dut.u_core_b.rgb_q;
        repeat (20) @(negedge HCLK);
        check("dls_sticky", 32'(DLS_ERROR), 32'd1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("dls_cleared", 32'(DLS_ERROR), 32'd0);
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);
        check("dls_after_rst", 32'(DLS_ERROR), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
